// File: rtl/cache_pkg.sv
// Shared types and constants for the 4-way set-associative cache controller.
// Default geometry: 32-bit byte address, 64 sets, 64-byte lines.
package cache_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_SETS_LOG2 = 6;
    localparam int DEF_LINE_LOG2 = 6;
    localparam int DEF_CNT_W     = 32;

    localparam int WAYS  = 4;
    localparam int WAY_W = 2;
    localparam int LRU_W = 6;

    typedef logic [LRU_W-1:0] lru_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL,
        RESP
    } state_t;

endpackage

// File: rtl/cache_set_controller_if.sv
// CPU request/response port of the cache controller.
// The CPU side is the master; the controller is the slave.
interface cache_set_controller_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic              done;
    logic              hit;
    logic [WAY_W-1:0]  way;

    modport master (
        output req, we, addr,
        input  ready, done, hit, way
    );

    modport slave (
        input  req, we, addr,
        output ready, done, hit, way
    );
endinterface

// File: rtl/cache_set_controller_lru.sv
// Pairwise 6-bit LRU for one 4-way set: next-state for an MRU touch and LRU way select.
// Bit meaning (1 = first way used more recently): b5=0v1 b4=0v2 b3=0v3 b2=1v2 b1=1v3 b0=2v3.
module cache_set_controller_lru
    import cache_pkg::*;
(
    input  lru_t             lru_in,
    input  logic [WAY_W-1:0] mru_way,
    output logic [WAY_W-1:0] lru_way,
    output lru_t             lru_next
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lru_next = lru_in;
        unique case (mru_way)
            2'd0: begin
                lru_next[5] = 1'b1;
                lru_next[4] = 1'b1;
                lru_next[3] = 1'b1;
            end
            2'd1: begin
                lru_next[5] = 1'b0;
                lru_next[2] = 1'b1;
                lru_next[1] = 1'b1;
            end
            2'd2: begin
                lru_next[4] = 1'b0;
                lru_next[2] = 1'b0;
                lru_next[0] = 1'b1;
            end
            default: begin
                lru_next[3] = 1'b0;
                lru_next[1] = 1'b0;
                lru_next[0] = 1'b0;
            end
        endcase
    end

    // The LRU way is the one older than all three others.
    always_comb begin
        if (!lru_in[5] && !lru_in[4] && !lru_in[3]) begin
            lru_way = 2'd0;
        end else if (lru_in[5] && !lru_in[2] && !lru_in[1]) begin
            lru_way = 2'd1;
        end else if (lru_in[4] && lru_in[2] && !lru_in[0]) begin
            lru_way = 2'd2;
        end else begin
            lru_way = 2'd3;
        end
    end

endmodule

// File: rtl/cache_set_controller.sv
// 4-way set-associative cache controller: tag lookup, victim choice, dirty writeback and
// line fill for one CPU port. Owns tag/valid/dirty/LRU state; the data array is external.
module cache_set_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SETS_LOG2 = DEF_SETS_LOG2,
    parameter int LINE_LOG2 = DEF_LINE_LOG2,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_set_controller_if.slave cpu,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    output logic [SETS_LOG2-1:0] data_set,
    output logic [WAY_W-1:0]     data_way,
    output logic                 data_evict,
    output logic                 data_fill,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);

    localparam int SETS    = 1 << SETS_LOG2;
    localparam int TAG_LSB = SETS_LOG2 + LINE_LOG2;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    state_t               state_q, state_d;
    logic                 req_we_q;
    logic [TAG_W-1:0]     req_tag_q;
    logic [SETS_LOG2-1:0] req_set_q;
    logic [WAY_W-1:0]     way_q;
    logic                 hit_q;
    logic                 evict_q;

    logic [TAG_W-1:0]     tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]      valid_mem [SETS];
    logic [WAYS-1:0]      dirty_mem [SETS];
    lru_t                 lru_mem   [SETS];

    logic [WAYS-1:0]      hit_vec;
    logic                 lookup_hit;
    logic                 any_free;
    logic                 victim_dirty;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     free_way;
    logic [WAY_W-1:0]     lru_way;
    logic [WAY_W-1:0]     victim_way;
    logic [WAY_W-1:0]     mru_way;
    logic [TAG_W-1:0]     victim_tag;
    lru_t                 lru_cur;
    lru_t                 lru_next;

    // ---------------- lookup ----------------
    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_mem[req_set_q][w] && (tag_mem[req_set_q][w] == req_tag_q);
        end
    end

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        any_free = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!valid_mem[req_set_q][w]) begin
                free_way = WAY_W'(w);
                any_free = 1'b1;
            end
        end
    end

    assign lookup_hit   = |hit_vec;
    assign victim_way   = any_free ? free_way : lru_way;
    assign victim_dirty = valid_mem[req_set_q][victim_way] && dirty_mem[req_set_q][victim_way];
    assign victim_tag   = tag_mem[req_set_q][way_q];
    assign lru_cur      = lru_mem[req_set_q];
    assign mru_way      = (state_q == LOOKUP) ? hit_way : way_q;

    cache_set_controller_lru u_lru (
        .lru_in   (lru_cur),
        .mru_way  (mru_way),
        .lru_way  (lru_way),
        .lru_next (lru_next)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cpu.ready = 1'b0;
        cpu.done  = 1'b0;
        cpu.hit   = 1'b0;
        cpu.way   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        data_fill = 1'b0;
        unique case (state_q)
            IDLE: begin
                cpu.ready = 1'b1;
                if (cpu.req) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    state_d = RESP;
                end else if (victim_dirty) begin
                    state_d = WB;
                end else begin
                    state_d = FILL;
                end
            end
            WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {victim_tag, req_set_q, {LINE_LOG2{1'b0}}};
                if (mem_ack) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag_q, req_set_q, {LINE_LOG2{1'b0}}};
                if (mem_ack) begin
                    data_fill = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                cpu.done = 1'b1;
                cpu.hit  = hit_q;
                cpu.way  = way_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- request capture, lookup result, statistics ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_we_q  <= 1'b0;
            req_tag_q <= '0;
            req_set_q <= '0;
            way_q     <= '0;
            hit_q     <= 1'b0;
            evict_q   <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            evict_q <= (state_q == LOOKUP) && (state_d == WB);
            if (state_q == IDLE && cpu.req) begin
                req_we_q  <= cpu.we;
                req_tag_q <= cpu.addr[ADDR_W-1:TAG_LSB];
                req_set_q <= cpu.addr[TAG_LSB-1:LINE_LOG2];
            end
            if (state_q == LOOKUP) begin
                hit_q <= lookup_hit;
                way_q <= lookup_hit ? hit_way : victim_way;
                if (lookup_hit) begin
                    if (hit_cnt != '1) begin
                        hit_cnt <= hit_cnt + CNT_W'(1);
                    end
                end else if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ---------------- valid / dirty / LRU arrays ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                lru_mem[s]   <= '0;
            end
        end else begin
            if (state_q == LOOKUP && lookup_hit) begin
                lru_mem[req_set_q] <= lru_next;
                if (req_we_q) begin
                    dirty_mem[req_set_q][hit_way] <= 1'b1;
                end
            end
            if (data_fill) begin
                valid_mem[req_set_q][way_q] <= 1'b1;
                dirty_mem[req_set_q][way_q] <= req_we_q;
                lru_mem[req_set_q]          <= lru_next;
            end
        end
    end

    // NOTE: the tag array has no reset; a tag is never looked at while its valid bit is 0.
    always_ff @(posedge clk) begin
        if (data_fill) begin
            tag_mem[req_set_q][way_q] <= req_tag_q;
        end
    end

    assign data_set   = req_set_q;
    assign data_way   = way_q;
    assign data_evict = evict_q;

endmodule

// File: tb/tb_cache_set_controller.sv
// Scoreboard bench for cache_set_controller: directed accesses push expected CPU and
// memory transactions; a CPU monitor and a memory responder pop and compare them.
module tb_cache_set_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [5:0]  data_set;
    logic [1:0]  data_way;
    logic        data_evict, data_fill;
    logic [31:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_set_controller_if cpu ();

    cache_set_controller dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpu),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .data_set   (data_set),
        .data_way   (data_way),
        .data_evict (data_evict),
        .data_fill  (data_fill),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    typedef struct {
        logic       hit;
        logic [1:0] way;
    } cpu_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_ack_cyc = 0;
    int done_cnt = 0;
    int evict_cnt = 0;
    int fill_cnt = 0;
    int mem_lat = 1;
    int stray_req = 0;
    int stray_done = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [1:0] evict_way = '0;
    logic [1:0] fill_way = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CPU-side monitor: sampled 1 time unit after the falling edge.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (data_evict) begin
                evict_cnt++;
                evict_way = data_way;
            end
            if (data_fill) begin
                fill_cnt++;
                fill_way = data_way;
            end
            if (cpu.done) begin
                done_cnt++;
                if (cpu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual hit=%0d way=%0d expected no completion",
                             cpu.hit, cpu.way);
                end else begin
                    e = cpu_q.pop_front();
                    check("done_hit", 32'(cpu.hit), 32'(e.hit));
                    check("done_way", 32'(cpu.way), 32'(e.way));
                    if (e.hit) check("hit_accept_to_done", cyc - accept_cyc, 2);
                    else       check("miss_ack_to_done", cyc - last_ack_cyc, 1);
                end
            end
        end
    end

    // Memory responder: compares each new request, then acks after mem_lat cycles.
    initial begin
        int       wait_n;
        bit       seen;
        mem_exp_t m;
        mem_ack = 1'b0;
        seen    = 1'b0;
        wait_n  = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!mem_req) begin
                seen = 1'b0;
                if (stray_req != stray_done) begin
                    mem_ack = 1'b1;
                    stray_done++;
                end
            end else begin
                if (!seen) begin
                    seen   = 1'b1;
                    wait_n = mem_lat;
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_req actual we=%0d addr=0x%h expected no request",
                                 mem_we, mem_addr);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_we", 32'(mem_we), 32'(m.we));
                        check("mem_addr", mem_addr, m.addr);
                    end
                end
                if (wait_n == 0) begin
                    mem_ack      = 1'b1;
                    seen         = 1'b0;
                    last_ack_cyc = cyc;
                end else begin
                    wait_n--;
                end
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        cpu.req  = 1'b0;
        cpu.we   = 1'b0;
        cpu.addr = '0;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        check("rst_ready", 32'(cpu.ready), 1);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_done", 32'(cpu.done), 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_lru_set0", 32'(dut.lru_mem[0]), 0);
    endtask

    task automatic expect_mem(input logic we, input logic [31:0] addr);
        mem_exp_t m;
        m.we   = we;
        m.addr = addr;
        mem_q.push_back(m);
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic hit,
                          input logic [1:0] way, input int hold);
        cpu_exp_t e;
        int start;
        int n;
        n = 0;
        while (!cpu.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 32'(cpu.ready), 1);
        e.hit = hit;
        e.way = way;
        cpu_q.push_back(e);
        start      = done_cnt;
        cpu.req    = 1'b1;
        cpu.we     = we;
        cpu.addr   = addr;
        accept_cyc = cyc;
        @(negedge clk);
        if (hold > 0) begin
            cpu.addr = addr ^ 32'h0000_3000;
            repeat (hold) @(negedge clk);
        end
        cpu.req = 1'b0;
        if (hit) exp_hits++;
        else     exp_misses++;
        n = 0;
        while (done_cnt == start && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_count", done_cnt - start, 1);
    endtask

    task automatic miss_read(input logic [31:0] addr, input logic [1:0] way);
        expect_mem(1'b0, {addr[31:6], 6'd0});
        access(1'b0, addr, 1'b0, way, 0);
    endtask

    task automatic check_lru(input string name, input logic [5:0] exp);
        check(name, 32'(dut.lru_mem[0]), 32'(exp));
    endtask

    task automatic check_counts();
        check("hit_cnt", hit_cnt, exp_hits);
        check("miss_cnt", miss_cnt, exp_misses);
    endtask

    task automatic fill_set0();
        miss_read(32'h0000_0000, 2'd0); check_lru("lru_after_w0", 6'h38);
        miss_read(32'h0000_1000, 2'd1); check_lru("lru_after_w1", 6'h1E);
        miss_read(32'h0000_2000, 2'd2); check_lru("lru_after_w2", 6'h0B);
        miss_read(32'h0000_3000, 2'd3); check_lru("lru_after_w3", 6'h00);
    endtask

    initial begin
        int ev0;
        int fl0;
        int n;
        reset    = 1'b1;
        cpu.req  = 1'b0;
        cpu.we   = 1'b0;
        cpu.addr = '0;

        // 1: cold miss then hit
        do_reset();
        mem_lat = 2;
        miss_read(32'h0000_1000, 2'd0);
        check_lru("t1_lru", 6'h38);
        access(1'b0, 32'h0000_1000, 1'b1, 2'd0, 0);
        check_counts();

        // 2: fill set 0, next miss replaces clean way 0 without writeback
        do_reset();
        fill_set0();
        ev0 = evict_cnt;
        miss_read(32'h0000_4000, 2'd0);
        check_lru("t2_lru_final", 6'h38);
        check("t2_no_evict", evict_cnt - ev0, 0);
        check_counts();

        // 3: rereading way 0 makes way 1 the victim
        do_reset();
        fill_set0();
        access(1'b0, 32'h0000_0000, 1'b1, 2'd0, 0);
        check_lru("t3_lru_after_hit", 6'h38);
        miss_read(32'h0000_4000, 2'd1);
        check_lru("t3_lru_final", 6'h1E);
        check_counts();

        // 4: dirty victim is written back before the fill
        do_reset();
        mem_lat = 3;
        miss_read(32'h0000_0000, 2'd0);
        access(1'b1, 32'h0000_0000, 1'b1, 2'd0, 0);
        miss_read(32'h0000_1000, 2'd1);
        miss_read(32'h0000_2000, 2'd2);
        miss_read(32'h0000_3000, 2'd3);
        ev0 = evict_cnt;
        fl0 = fill_cnt;
        expect_mem(1'b1, 32'h0000_0000);
        expect_mem(1'b0, 32'h0000_4000);
        access(1'b0, 32'h0000_4000, 1'b0, 2'd0, 0);
        check("t4_evict_pulses", evict_cnt - ev0, 1);
        check("t4_fill_pulses", fill_cnt - fl0, 1);
        check("t4_evict_way", 32'(evict_way), 0);
        check("t4_fill_way", 32'(fill_way), 0);
        check_counts();

        // 5: reset during FILL aborts the miss
        do_reset();
        mem_lat = 20;
        expect_mem(1'b0, 32'h0000_1000);
        cpu.req  = 1'b1;
        cpu.we   = 1'b0;
        cpu.addr = 32'h0000_1000;
        @(negedge clk);
        cpu.req = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_fill_req", 32'(mem_req), 1);
        #2 reset = 1'b1;
        #1;
        check("t5_mem_req_drop", 32'(mem_req), 0);
        check("t5_ready_in_reset", 32'(cpu.ready), 1);
        check("t5_fill_in_reset", 32'(data_fill), 0);
        check("t5_miss_cnt_reset", miss_cnt, 0);
        @(negedge clk);
        do_reset();
        mem_lat = 1;
        miss_read(32'h0000_1000, 2'd0);
        access(1'b0, 32'h0000_1000, 1'b1, 2'd0, 0);
        check_counts();

        // 6: ack latency extremes, ignored busy request, stray ack
        do_reset();
        mem_lat = 0;
        miss_read(32'h0000_1000, 2'd0);
        mem_lat = 10;
        expect_mem(1'b0, 32'h0000_2000);
        access(1'b0, 32'h0000_2000, 1'b0, 2'd1, 5);
        stray_req++;
        repeat (4) @(negedge clk);
        check("t6_idle_after_stray_ack", 32'(cpu.ready), 1);
        check("t6_miss_cnt_after_stray", miss_cnt, 2);
        access(1'b0, 32'h0000_1000, 1'b1, 2'd0, 0);
        access(1'b0, 32'h0000_2000, 1'b1, 2'd1, 0);
        check("t6_hit_cnt", hit_cnt, 2);
        check_counts();

        repeat (3) @(negedge clk);
        check("cpu_queue_empty", cpu_q.size(), 0);
        check("mem_queue_empty", mem_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
